// File: rtl/pe_array_pkg.sv
// Shared types for the 3x3 conv PE array sequencer.
// Array geometry, weight type and controller state encoding.
package pe_array_pkg;

    localparam int KSIZE = 3;
    localparam int N_IN  = 6;
    localparam int N_OUT = 4;

    typedef logic [7:0] weight_t;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        LOAD_K,
        WK,
        STREAM,
        DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Handshake and data bundle between the sequencer and its neighbours.
// master = controller side, slave = kernel source / line buffer / array side.
interface pe_array_ctrl_if #(
    parameter int W_BITS = 8,
    parameter int S_BITS = 6
);
    import pe_array_pkg::*;

    logic                          start;
    logic [W_BITS-1:0]             cfg_width;
    logic [S_BITS-1:0]             cfg_strips;
    logic                          busy;
    logic                          done;
    logic                          cfg_err;
    logic                          k_valid;
    logic                          k_ready;
    weight_t [KSIZE*KSIZE-1:0]     k_data;
    weight_t [KSIZE*KSIZE-1:0]     weights;
    logic                          write_kernel;
    logic                          ifm_req;
    logic [S_BITS-1:0]             ifm_strip;
    logic [W_BITS-1:0]             ifm_col;
    logic                          out_valid;
    logic [S_BITS-1:0]             out_strip;
    logic [W_BITS-1:0]             out_col;

    modport master (
        input  start, cfg_width, cfg_strips,
        input  k_valid, k_data,
        output busy, done, cfg_err,
        output k_ready, weights, write_kernel,
        output ifm_req, ifm_strip, ifm_col,
        output out_valid, out_strip, out_col
    );

    modport slave (
        output start, cfg_width, cfg_strips,
        output k_valid, k_data,
        input  busy, done, cfg_err,
        input  k_ready, weights, write_kernel,
        input  ifm_req, ifm_strip, ifm_col,
        input  out_valid, out_strip, out_col
    );

endinterface

// File: rtl/ctrl_delay_line.sv
// Clearable shift register; aligns the request sideband with array latency.
// Output is the last register stage, so it is already registered.
module ctrl_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for the 3x3 conv PE array: kernel load, strip-wise ifmap
// streaming and output tagging aligned to line-buffer + array latency.
module pe_array_ctrl
    import pe_array_pkg::*;
#(
    parameter int W_BITS   = 8,
    parameter int S_BITS   = 6,
    parameter int RD_LAT   = 1,
    parameter int PIPE_LAT = 3
) (
    input logic           clk,
    input logic           rst,
    pe_array_ctrl_if.master bus
);

    localparam int DLY   = RD_LAT + PIPE_LAT;
    localparam int SB_W  = 1 + S_BITS + W_BITS;
    localparam int CNT_W = $clog2(DLY + 1);

    ctrl_state_t       state;
    logic [W_BITS-1:0] w_cfg;
    logic [S_BITS-1:0] s_cfg;
    logic [CNT_W-1:0]  drain_cnt;
    logic              last_col;
    logic              last_strip;
    logic              col_ok;
    logic              cfg_bad;
    logic [SB_W-1:0]   sb_in;
    logic [SB_W-1:0]   sb_out;

    assign last_col   = bus.ifm_col == w_cfg - W_BITS'(1);
    assign last_strip = bus.ifm_strip == s_cfg - S_BITS'(1);
    assign cfg_bad    = (bus.cfg_width < W_BITS'(3))
                      || (bus.cfg_strips == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            w_cfg            <= '0;
            s_cfg            <= '0;
            drain_cnt        <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.cfg_err      <= 1'b0;
            bus.k_ready      <= 1'b0;
            bus.weights      <= '0;
            bus.write_kernel <= 1'b0;
            bus.ifm_req      <= 1'b0;
            bus.ifm_strip    <= '0;
            bus.ifm_col      <= '0;
        end else begin
            bus.done         <= 1'b0;
            bus.cfg_err      <= 1'b0;
            bus.write_kernel <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        w_cfg <= bus.cfg_width;
                        s_cfg <= bus.cfg_strips;
                        if (cfg_bad) begin
                            state       <= ERR;
                            bus.done    <= 1'b1;
                            bus.cfg_err <= 1'b1;
                        end else begin
                            state       <= LOAD_K;
                            bus.busy    <= 1'b1;
                            bus.k_ready <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                LOAD_K: begin
                    if (bus.k_valid && bus.k_ready) begin
                        bus.weights      <= bus.k_data;
                        bus.k_ready      <= 1'b0;
                        bus.write_kernel <= 1'b1;
                        state            <= WK;
                    end
                end
                WK: begin
                    state         <= STREAM;
                    bus.ifm_req   <= 1'b1;
                    bus.ifm_col   <= '0;
                    bus.ifm_strip <= '0;
                end
                STREAM: begin
                    if (last_col) begin
                        bus.ifm_col <= '0;
                        if (last_strip) begin
                            bus.ifm_req <= 1'b0;
                            drain_cnt   <= CNT_W'(DLY - 1);
                            state       <= DRAIN;
                        end else begin
                            bus.ifm_strip <= bus.ifm_strip + S_BITS'(1);
                        end
                    end else begin
                        bus.ifm_col <= bus.ifm_col + W_BITS'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Windows ending at col 0/1 would straddle the previous strip.
    assign col_ok = bus.ifm_col >= W_BITS'(2);
    assign sb_in  = {bus.ifm_req && col_ok, bus.ifm_strip,
                     bus.ifm_col - W_BITS'(2)};

    ctrl_delay_line #(
        .DEPTH (DLY),
        .WIDTH (SB_W)
    ) u_dly (
        .clk  (clk),
        .clr  (rst),
        .din  (sb_in),
        .dout (sb_out)
    );

    assign {bus.out_valid, bus.out_strip, bus.out_col} = sb_out;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl: kernel load, strip streaming,
// sideband alignment, config errors and mid-run reset.
module tb_pe_array_ctrl;
    import pe_array_pkg::*;

    localparam int W_BITS = 8;
    localparam int S_BITS = 6;
    localparam int LAT    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_array_ctrl_if #(.W_BITS(W_BITS), .S_BITS(S_BITS)) bus ();

    pe_array_ctrl #(
        .W_BITS(W_BITS), .S_BITS(S_BITS), .RD_LAT(1), .PIPE_LAT(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int ifm_q[$];
    int ifm_t[$];
    int out_q[$];
    int out_t[$];
    int wk_n, done_n, err_n, done_t;

    logic [71:0] kern_a = 72'h09_08_07_06_05_04_03_02_01;
    logic [71:0] kern_b = 72'hF1_E2_D3_C4_B5_A6_97_88_79;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ifm_req) begin
            ifm_q.push_back(int'(bus.ifm_strip) * 256 + int'(bus.ifm_col));
            ifm_t.push_back(cyc);
        end
        if (bus.out_valid) begin
            out_q.push_back(int'(bus.out_strip) * 256 + int'(bus.out_col));
            out_t.push_back(cyc);
        end
        if (bus.write_kernel) wk_n++;
        if (bus.cfg_err) err_n++;
        if (bus.done) begin
            done_n++;
            done_t = cyc;
        end
    end

    task automatic clear_logs();
        ifm_q.delete(); ifm_t.delete();
        out_q.delete(); out_t.delete();
        wk_n = 0; done_n = 0; err_n = 0; done_t = -1;
    endtask

    task automatic start_run(input int w, input int s);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.cfg_width  = W_BITS'(w);
        bus.cfg_strips = S_BITS'(s);
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.cfg_width  = 8'd2;
        bus.cfg_strips = 6'd0;
    endtask

    task automatic send_kernel(input logic [71:0] k, output bit to);
        to = 1'b1;
        bus.k_valid = 1'b1;
        bus.k_data  = k;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.k_ready) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        bus.k_valid = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.done) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.cfg_err, bus.k_ready,
             bus.write_kernel, bus.ifm_req, bus.out_valid} !== 7'b0) begin
            $display("FAIL reset_ctrl got=%b exp=0",
                {bus.busy, bus.done, bus.cfg_err, bus.k_ready,
                 bus.write_kernel, bus.ifm_req, bus.out_valid});
        end else n_pass++;
        n_chk++;
        if (bus.weights !== 72'h0) begin
            $display("FAIL reset_weights got=%h exp=0", bus.weights);
        end else n_pass++;
        n_chk++;
        if ({bus.ifm_col, bus.ifm_strip, bus.out_col, bus.out_strip} !== '0) begin
            $display("FAIL reset_idx got=%h exp=0",
                {bus.ifm_col, bus.ifm_strip, bus.out_col, bus.out_strip});
        end else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_strip();
        bit to_k, to_d;
        clear_logs();
        start_run(6, 1);
        send_kernel(kern_a, to_k);
        wait_done(to_d);
        n_chk++;
        if (to_k || to_d) $display("FAIL single_timeout got=%b%b exp=00", to_k, to_d);
        else n_pass++;
        n_chk++;
        if (wk_n !== 1) $display("FAIL single_wk got=%0d exp=1", wk_n);
        else n_pass++;
        n_chk++;
        if (bus.weights !== kern_a) $display("FAIL single_weights got=%h exp=%h", bus.weights, kern_a);
        else n_pass++;
        n_chk++;
        if (ifm_q.size() !== 6) $display("FAIL single_ifm_n got=%0d exp=6", ifm_q.size());
        else n_pass++;
        for (int i = 0; i < ifm_q.size() && i < 6; i++) begin
            n_chk++;
            if (ifm_q[i] !== i || ifm_t[i] !== ifm_t[0] + i)
                $display("FAIL single_ifm%0d got=%0d@%0d exp=%0d@%0d",
                    i, ifm_q[i], ifm_t[i], i, ifm_t[0] + i);
            else n_pass++;
        end
        n_chk++;
        if (out_q.size() !== 4) $display("FAIL single_out_n got=%0d exp=4", out_q.size());
        else n_pass++;
        for (int i = 0; i < out_q.size() && i < 4 && ifm_t.size() == 6; i++) begin
            n_chk++;
            if (out_q[i] !== i || out_t[i] !== ifm_t[2] + LAT + i)
                $display("FAIL single_out%0d got=%0d@%0d exp=%0d@%0d",
                    i, out_q[i], out_t[i], i, ifm_t[2] + LAT + i);
            else n_pass++;
        end
        if (ifm_t.size() == 6) begin
            n_chk++;
            if (done_t !== ifm_t[5] + LAT + 1)
                $display("FAIL single_done_t got=%0d exp=%0d", done_t, ifm_t[5] + LAT + 1);
            else n_pass++;
        end
        n_chk++;
        if (done_n !== 1 || err_n !== 0 || bus.busy !== 1'b0)
            $display("FAIL single_done got=%0d/%0d/%b exp=1/0/0", done_n, err_n, bus.busy);
        else n_pass++;
    endtask

    task automatic test_two_strips();
        bit to_k, to_d;
        int exp_o[4];
        clear_logs();
        exp_o = '{0, 1, 256, 257};
        start_run(4, 2);
        send_kernel(kern_b, to_k);
        wait_done(to_d);
        n_chk++;
        if (to_k || to_d) $display("FAIL two_timeout got=%b%b exp=00", to_k, to_d);
        else n_pass++;
        n_chk++;
        if (ifm_q.size() !== 8) $display("FAIL two_ifm_n got=%0d exp=8", ifm_q.size());
        else n_pass++;
        for (int i = 0; i < ifm_q.size() && i < 8; i++) begin
            n_chk++;
            if (ifm_q[i] !== (i / 4) * 256 + (i % 4) || ifm_t[i] !== ifm_t[0] + i)
                $display("FAIL two_ifm%0d got=%0d@%0d exp=%0d@%0d", i, ifm_q[i],
                    ifm_t[i], (i / 4) * 256 + (i % 4), ifm_t[0] + i);
            else n_pass++;
        end
        n_chk++;
        if (out_q.size() !== 4) $display("FAIL two_out_n got=%0d exp=4", out_q.size());
        else n_pass++;
        for (int i = 0; i < out_q.size() && i < 4; i++) begin
            n_chk++;
            if (out_q[i] !== exp_o[i])
                $display("FAIL two_out%0d got=%0h exp=%0h", i, out_q[i], exp_o[i]);
            else n_pass++;
        end
        if (ifm_t.size() == 8 && out_t.size() == 4) begin
            n_chk++;
            if (out_t[2] !== ifm_t[6] + LAT)
                $display("FAIL two_s1_align got=%0d exp=%0d", out_t[2], ifm_t[6] + LAT);
            else n_pass++;
        end
    endtask

    task automatic test_kernel_wait();
        bit to_k, to_d;
        bit bad = 1'b0;
        clear_logs();
        start_run(5, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.k_ready !== 1'b1 || bus.ifm_req !== 1'b0 || bus.write_kernel !== 1'b0)
                bad = 1'b1;
        end
        n_chk++;
        if (bad) $display("FAIL kwait_hold got=bad exp=k_ready_only");
        else n_pass++;
        n_chk++;
        if (wk_n !== 0 || ifm_q.size() !== 0)
            $display("FAIL kwait_idle got=%0d/%0d exp=0/0", wk_n, ifm_q.size());
        else n_pass++;
        @(posedge clk); #1;
        send_kernel(kern_a, to_k);
        wait_done(to_d);
        n_chk++;
        if (to_k || to_d || wk_n !== 1 || ifm_q.size() !== 5 || out_q.size() !== 3)
            $display("FAIL kwait_run got=%b%b/%0d/%0d/%0d exp=00/1/5/3",
                to_k, to_d, wk_n, ifm_q.size(), out_q.size());
        else n_pass++;
        n_chk++;
        if (bus.weights !== kern_a) $display("FAIL kwait_weights got=%h exp=%h", bus.weights, kern_a);
        else n_pass++;
    endtask

    task automatic test_cfg_err();
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            start_run(k == 0 ? 2 : 6, k == 0 ? 1 : 0);
            @(negedge clk);
            n_chk++;
            if (bus.done !== 1'b1 || bus.cfg_err !== 1'b1 || bus.busy !== 1'b0)
                $display("FAIL err%0d_pulse got=%b%b%b exp=110",
                    k, bus.done, bus.cfg_err, bus.busy);
            else n_pass++;
            repeat (6) @(negedge clk);
            n_chk++;
            if (done_n !== 1 || err_n !== 1 || wk_n !== 0 || ifm_q.size() !== 0 || bus.k_ready !== 1'b0)
                $display("FAIL err%0d_after got=%0d/%0d/%0d/%0d/%b exp=1/1/0/0/0",
                    k, done_n, err_n, wk_n, ifm_q.size(), bus.k_ready);
            else n_pass++;
        end
    endtask

    task automatic test_start_busy();
        bit to_k, to_d;
        clear_logs();
        start_run(4, 1);
        send_kernel(kern_b, to_k);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.cfg_width  = 8'd2;
        bus.cfg_strips = 6'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(to_d);
        n_chk++;
        if (to_k || to_d || done_n !== 1 || err_n !== 0 || ifm_q.size() !== 4 || out_q.size() !== 2)
            $display("FAIL busy_start got=%b%b/%0d/%0d/%0d/%0d exp=00/1/0/4/2",
                to_k, to_d, done_n, err_n, ifm_q.size(), out_q.size());
        else n_pass++;
        repeat (4) @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || done_n !== 1)
            $display("FAIL busy_idle got=%b/%0d exp=0/1", bus.busy, done_n);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to_k, to_d;
        bit seen = 1'b0;
        clear_logs();
        start_run(8, 2);
        send_kernel(kern_a, to_k);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ifm_req && bus.ifm_col == 8'd5) begin
                seen = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!seen || to_k) $display("FAIL mid_reach got=%b%b exp=10", seen, to_k);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.ifm_req !== 1'b0)
            $display("FAIL mid_rst got=%b%b%b exp=000", bus.busy, bus.out_valid, bus.ifm_req);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++;
        if (done_n !== 0 || out_q.size() !== 0 || ifm_q.size() !== 0)
            $display("FAIL mid_quiet got=%0d/%0d/%0d exp=0/0/0",
                done_n, out_q.size(), ifm_q.size());
        else n_pass++;
        @(posedge clk); #1;
        clear_logs();
        start_run(5, 1);
        send_kernel(kern_b, to_k);
        wait_done(to_d);
        n_chk++;
        if (to_k || to_d || wk_n !== 1 || ifm_q.size() !== 5 || out_q.size() !== 3 || done_n !== 1)
            $display("FAIL mid_rerun got=%b%b/%0d/%0d/%0d/%0d exp=00/1/5/3/1",
                to_k, to_d, wk_n, ifm_q.size(), out_q.size(), done_n);
        else n_pass++;
        if (out_q.size() == 3) begin
            n_chk++;
            if (out_q[0] !== 0 || out_q[2] !== 2)
                $display("FAIL mid_rerun_cols got=%0d,%0d exp=0,2", out_q[0], out_q[2]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.cfg_width  = '0;
        bus.cfg_strips = '0;
        bus.k_valid    = 1'b0;
        bus.k_data     = '0;
        clear_logs();
        test_reset();
        test_single_strip();
        test_two_strips();
        test_kernel_wait();
        test_cfg_err();
        test_start_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
